// File: rtl/cache_axi_pkg.sv
// Shared types and AXI attribute constants for the cache refill arbiter.
package cache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } refill_state_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_t;

  localparam logic [3:0] ARCACHE_NORM = 4'b0110;
  localparam logic [2:0] ARPROT_INSTR = 3'b100;
  localparam logic [2:0] ARPROT_DATA  = 3'b000;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant; the last-grant register moves only when a
// grant is actually taken, so a tie always goes to the side served least recently.
module rr_arbiter_2
  import cache_axi_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_req_ic,
  input  logic   i_req_dc,
  input  logic   i_grant_en,
  output logic   o_grant_valid,
  output owner_t o_grant_owner
);

  owner_t r_last;

  // Combinational winner selection from current requests and last grant.
  always_comb begin
    o_grant_valid = i_req_ic | i_req_dc;
    o_grant_owner = OWNER_IC;
    if (i_req_ic && i_req_dc) begin
      o_grant_owner = (r_last == OWNER_IC) ? OWNER_DC : OWNER_IC;
    end else if (i_req_dc) begin
      o_grant_owner = OWNER_DC;
    end
  end

  // Remember who was served; reset to D-cache so the I-cache wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= OWNER_DC;
    end else if (i_grant_en && o_grant_valid) begin
      r_last <= o_grant_owner;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one single-beat AXI read path between I-cache and D-cache line refills.
// All outputs are registered; the next-state block computes their next values.
module cache_refill_arbiter
  import cache_axi_pkg::*;
#(
  parameter int unsigned WIDTH_ADD = 32,
  parameter int unsigned DATA      = 32,
  parameter int unsigned N_WORD    = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   AXI_CLK,
  input  logic                   AXI_RESETn,
  input  logic                   IC_REQ,
  input  logic [WIDTH_ADD-1:0]   IC_ADDR,
  output logic [DATA*N_WORD-1:0] IC_LINE,
  output logic                   IC_VALID,
  input  logic                   DC_REQ,
  input  logic [WIDTH_ADD-1:0]   DC_ADDR,
  output logic [DATA*N_WORD-1:0] DC_LINE,
  output logic                   DC_VALID,
  output logic                   REFILL_ERR,
  output logic                   AXI_ARVALID,
  input  logic                   AXI_ARREADY,
  output logic [WIDTH_ADD-1:0]   AXI_ARADDR,
  output logic [2:0]             AXI_ARPROT,
  output logic [3:0]             AXI_ARCACHE,
  input  logic                   AXI_RVALID,
  input  logic [DATA*N_WORD-1:0] AXI_RDATA,
  input  logic [1:0]             AXI_RRESP,
  output logic                   AXI_RREADY
);

  localparam int unsigned LINE_W  = DATA * N_WORD;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  refill_state_t          r_state,    w_state_nxt;
  owner_t                 r_owner,    w_owner_nxt;
  logic                   r_arvalid,  w_arvalid_nxt;
  logic [WIDTH_ADD-1:0]   r_araddr,   w_araddr_nxt;
  logic [2:0]             r_arprot,   w_arprot_nxt;
  logic [3:0]             r_arcache,  w_arcache_nxt;
  logic                   r_rready,   w_rready_nxt;
  logic [7:0]             r_cnt,      w_cnt_nxt;
  logic                   r_ic_valid, w_ic_valid_nxt;
  logic                   r_dc_valid, w_dc_valid_nxt;
  logic [LINE_W-1:0]      r_ic_line,  w_ic_line_nxt;
  logic [LINE_W-1:0]      r_dc_line,  w_dc_line_nxt;
  logic                   r_err,      w_err_nxt;

  logic                   w_grant_en;
  logic                   w_grant_valid;
  owner_t                 w_grant_owner;
  logic                   w_resp_err;
  logic [LINE_W-1:0]      w_rx_line;

  assign w_grant_en = (r_state == IDLE);
  assign w_resp_err = (AXI_RRESP != RESP_OKAY);
  assign w_rx_line  = w_resp_err ? '0 : AXI_RDATA;

  rr_arbiter_2 u_rr (
    .i_clk         (AXI_CLK),
    .i_rst_n       (AXI_RESETn),
    .i_req_ic      (IC_REQ),
    .i_req_dc      (DC_REQ),
    .i_grant_en    (w_grant_en),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  // Next-state and next-output logic for the refill sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_arvalid_nxt  = r_arvalid;
    w_araddr_nxt   = r_araddr;
    w_arprot_nxt   = r_arprot;
    w_arcache_nxt  = r_arcache;
    w_rready_nxt   = r_rready;
    w_cnt_nxt      = r_cnt;
    w_ic_valid_nxt = 1'b0;
    w_dc_valid_nxt = 1'b0;
    w_ic_line_nxt  = '0;
    w_dc_line_nxt  = '0;
    w_err_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        w_arvalid_nxt = 1'b0;
        w_araddr_nxt  = '0;
        w_arprot_nxt  = '0;
        w_arcache_nxt = '0;
        w_rready_nxt  = 1'b0;
        if (w_grant_valid) begin
          w_state_nxt   = ADDR;
          w_owner_nxt   = w_grant_owner;
          w_arvalid_nxt = 1'b1;
          w_arcache_nxt = ARCACHE_NORM;
          if (w_grant_owner == OWNER_IC) begin
            w_araddr_nxt = IC_ADDR;
            w_arprot_nxt = ARPROT_INSTR;
          end else begin
            w_araddr_nxt = DC_ADDR;
            w_arprot_nxt = ARPROT_DATA;
          end
        end
      end

      ADDR: begin
        if (AXI_ARREADY) begin
          w_state_nxt   = WAIT_R;
          w_arvalid_nxt = 1'b0;
          w_araddr_nxt  = '0;
          w_arprot_nxt  = '0;
          w_arcache_nxt = '0;
          w_rready_nxt  = 1'b1;
          w_cnt_nxt     = '0;
        end
      end

      WAIT_R: begin
        // Data is checked before the watchdog so a response on the last cycle wins.
        if (AXI_RVALID) begin
          w_state_nxt  = DONE;
          w_rready_nxt = 1'b0;
          w_err_nxt    = w_resp_err;
          if (r_owner == OWNER_IC) begin
            w_ic_valid_nxt = 1'b1;
            w_ic_line_nxt  = w_rx_line;
          end else begin
            w_dc_valid_nxt = 1'b1;
            w_dc_line_nxt  = w_rx_line;
          end
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt  = DONE;
          w_rready_nxt = 1'b0;
          w_err_nxt    = 1'b1;
          if (r_owner == OWNER_IC) begin
            w_ic_valid_nxt = 1'b1;
          end else begin
            w_dc_valid_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
    if (!AXI_RESETn) begin
      r_state    <= IDLE;
      r_owner    <= OWNER_IC;
      r_arvalid  <= 1'b0;
      r_araddr   <= '0;
      r_arprot   <= '0;
      r_arcache  <= '0;
      r_rready   <= 1'b0;
      r_cnt      <= '0;
      r_ic_valid <= 1'b0;
      r_dc_valid <= 1'b0;
      r_ic_line  <= '0;
      r_dc_line  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_arvalid  <= w_arvalid_nxt;
      r_araddr   <= w_araddr_nxt;
      r_arprot   <= w_arprot_nxt;
      r_arcache  <= w_arcache_nxt;
      r_rready   <= w_rready_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ic_valid <= w_ic_valid_nxt;
      r_dc_valid <= w_dc_valid_nxt;
      r_ic_line  <= w_ic_line_nxt;
      r_dc_line  <= w_dc_line_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign AXI_ARVALID = r_arvalid;
  assign AXI_ARADDR  = r_araddr;
  assign AXI_ARPROT  = r_arprot;
  assign AXI_ARCACHE = r_arcache;
  assign AXI_RREADY  = r_rready;
  assign IC_VALID    = r_ic_valid;
  assign DC_VALID    = r_dc_valid;
  assign IC_LINE     = r_ic_line;
  assign DC_LINE     = r_dc_line;
  assign REFILL_ERR  = r_err;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: refill, round-robin, AR stall,
// error response, watchdog timeout and asynchronous reset mid-transfer.
module tb_cache_refill_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          AXI_CLK;
  logic          AXI_RESETn;
  logic          IC_REQ;
  logic [AW-1:0] IC_ADDR;
  logic [LW-1:0] IC_LINE;
  logic          IC_VALID;
  logic          DC_REQ;
  logic [AW-1:0] DC_ADDR;
  logic [LW-1:0] DC_LINE;
  logic          DC_VALID;
  logic          REFILL_ERR;
  logic          AXI_ARVALID;
  logic          AXI_ARREADY;
  logic [AW-1:0] AXI_ARADDR;
  logic [2:0]    AXI_ARPROT;
  logic [3:0]    AXI_ARCACHE;
  logic          AXI_RVALID;
  logic [LW-1:0] AXI_RDATA;
  logic [1:0]    AXI_RRESP;
  logic          AXI_RREADY;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  cache_refill_arbiter #(
    .WIDTH_ADD (32),
    .DATA      (32),
    .N_WORD    (8),
    .TIMEOUT   (8)
  ) dut (
    .AXI_CLK     (AXI_CLK),
    .AXI_RESETn  (AXI_RESETn),
    .IC_REQ      (IC_REQ),
    .IC_ADDR     (IC_ADDR),
    .IC_LINE     (IC_LINE),
    .IC_VALID    (IC_VALID),
    .DC_REQ      (DC_REQ),
    .DC_ADDR     (DC_ADDR),
    .DC_LINE     (DC_LINE),
    .DC_VALID    (DC_VALID),
    .REFILL_ERR  (REFILL_ERR),
    .AXI_ARVALID (AXI_ARVALID),
    .AXI_ARREADY (AXI_ARREADY),
    .AXI_ARADDR  (AXI_ARADDR),
    .AXI_ARPROT  (AXI_ARPROT),
    .AXI_ARCACHE (AXI_ARCACHE),
    .AXI_RVALID  (AXI_RVALID),
    .AXI_RDATA   (AXI_RDATA),
    .AXI_RRESP   (AXI_RRESP),
    .AXI_RREADY  (AXI_RREADY)
  );

  initial AXI_CLK = 1'b0;
  always #5 AXI_CLK = ~AXI_CLK;

  // Count AR handshakes seen on the bus.
  always @(posedge AXI_CLK) begin
    if (AXI_ARVALID && AXI_ARREADY) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_CLK);
    #1;
  endtask

  logic [LW-1:0] line_a5;
  logic [LW-1:0] pat;
  logic [7:0]    b;
  bit            exp_ic;
  int            n;
  int            hs_before;

  initial begin
    line_a5     = {32{8'hA5}};
    AXI_RESETn  = 1'b0;
    IC_REQ      = 1'b0;
    IC_ADDR     = '0;
    DC_REQ      = 1'b0;
    DC_ADDR     = '0;
    AXI_ARREADY = 1'b0;
    AXI_RVALID  = 1'b0;
    AXI_RDATA   = '0;
    AXI_RRESP   = 2'b00;

    // Reset state
    tick(); tick();
    check_eq("rst_arvalid", LW'(AXI_ARVALID), '0);
    check_eq("rst_rready",  LW'(AXI_RREADY),  '0);
    check_eq("rst_valids",  LW'({IC_VALID, DC_VALID, REFILL_ERR}), '0);
    check_eq("rst_ar",      LW'({AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE}), '0);
    check_eq("rst_lines",   IC_LINE | DC_LINE, '0);
    AXI_RESETn = 1'b1;
    tick();

    // I-cache refill alone, minimum latency
    IC_REQ = 1'b1; IC_ADDR = 32'h100; AXI_ARREADY = 1'b1;
    tick();
    check_eq("t1_arvalid", LW'(AXI_ARVALID), LW'(1));
    check_eq("t1_araddr",  LW'(AXI_ARADDR),  LW'(32'h100));
    check_eq("t1_arprot",  LW'(AXI_ARPROT),  LW'(3'b100));
    check_eq("t1_arcache", LW'(AXI_ARCACHE), LW'(4'b0110));
    tick();
    check_eq("t1_ar_drop", LW'(AXI_ARVALID), '0);
    check_eq("t1_rready",  LW'(AXI_RREADY),  LW'(1));
    AXI_RVALID = 1'b1; AXI_RDATA = line_a5; AXI_RRESP = 2'b00;
    tick();
    check_eq("t1_ic_valid", LW'(IC_VALID),   LW'(1));
    check_eq("t1_dc_valid", LW'(DC_VALID),   '0);
    check_eq("t1_ic_line",  IC_LINE,         line_a5);
    check_eq("t1_err",      LW'(REFILL_ERR), '0);
    IC_REQ = 1'b0; AXI_RVALID = 1'b0;
    tick();
    check_eq("t1_pulse_end", LW'(IC_VALID), '0);
    check_eq("t1_line_clr",  IC_LINE,       '0);

    // D-cache refill with SLVERR response
    DC_REQ = 1'b1; DC_ADDR = 32'h2000;
    tick();
    check_eq("t2_araddr", LW'(AXI_ARADDR), LW'(32'h2000));
    check_eq("t2_arprot", LW'(AXI_ARPROT), LW'(3'b000));
    tick();
    AXI_RVALID = 1'b1; AXI_RDATA = {LW{1'b1}}; AXI_RRESP = 2'b10;
    tick();
    check_eq("t2_dc_valid", LW'(DC_VALID),   LW'(1));
    check_eq("t2_ic_valid", LW'(IC_VALID),   '0);
    check_eq("t2_err",      LW'(REFILL_ERR), LW'(1));
    check_eq("t2_dc_line",  DC_LINE,         '0);
    DC_REQ = 1'b0; AXI_RVALID = 1'b0; AXI_RRESP = 2'b00;
    tick();

    // Both requesting continuously: IC, DC, IC, DC
    IC_REQ = 1'b1; IC_ADDR = 32'h1100;
    DC_REQ = 1'b1; DC_ADDR = 32'h2200;
    for (int k = 0; k < 4; k++) begin
      exp_ic = (k % 2 == 0);
      b = 8'h10 + 8'(k);
      pat = {32{b}};
      tick();
      check_eq($sformatf("rr%0d_arprot", k), LW'(AXI_ARPROT), exp_ic ? LW'(3'b100) : LW'(3'b000));
      check_eq($sformatf("rr%0d_araddr", k), LW'(AXI_ARADDR), exp_ic ? LW'(32'h1100) : LW'(32'h2200));
      tick();
      AXI_RVALID = 1'b1; AXI_RDATA = pat;
      tick();
      AXI_RVALID = 1'b0;
      check_eq($sformatf("rr%0d_valids", k), LW'({IC_VALID, DC_VALID}), exp_ic ? LW'(2'b10) : LW'(2'b01));
      check_eq($sformatf("rr%0d_line", k), exp_ic ? IC_LINE : DC_LINE, pat);
      tick();
    end
    IC_REQ = 1'b0; DC_REQ = 1'b0;

    // AR stall: ARREADY low for 5 cycles
    hs_before = hs_cnt;
    AXI_ARREADY = 1'b0;
    IC_REQ = 1'b1; IC_ADDR = 32'h300;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("st%0d_arvalid", i), LW'(AXI_ARVALID), LW'(1));
      check_eq($sformatf("st%0d_araddr", i),  LW'(AXI_ARADDR),  LW'(32'h300));
      if (i < 4) tick();
    end
    AXI_ARREADY = 1'b1;
    tick();
    check_eq("st_ar_drop", LW'(AXI_ARVALID), '0);
    AXI_RVALID = 1'b1; AXI_RDATA = line_a5;
    tick();
    AXI_RVALID = 1'b0;
    check_eq("st_ic_valid", LW'(IC_VALID), LW'(1));
    check_eq("st_handshakes", LW'(hs_cnt - hs_before), LW'(1));
    IC_REQ = 1'b0;
    tick();

    // No read response: watchdog completes with error after 8 WAIT_R cycles
    DC_REQ = 1'b1; DC_ADDR = 32'h4000;
    tick();
    tick();
    n = 0;
    while (!DC_VALID && n < 20) begin
      tick();
      n++;
    end
    check_eq("to_cycles", LW'(n),           LW'(8));
    check_eq("to_err",    LW'(REFILL_ERR),  LW'(1));
    check_eq("to_line",   DC_LINE,          '0);
    DC_REQ = 1'b0;
    tick();
    check_eq("to_pulse_end", LW'(DC_VALID), '0);

    // Async reset during WAIT_R
    IC_REQ = 1'b1; IC_ADDR = 32'h500;
    tick();
    tick();
    check_eq("ar_rready_pre", LW'(AXI_RREADY), LW'(1));
    #1 AXI_RESETn = 1'b0;
    #1;
    check_eq("ar_outs_zero", LW'({AXI_ARVALID, AXI_RREADY, IC_VALID, DC_VALID, REFILL_ERR}), '0);
    IC_REQ = 1'b0;
    AXI_RVALID = 1'b1; AXI_RDATA = line_a5;
    tick();
    check_eq("ar_no_pulse", LW'({IC_VALID, DC_VALID}), '0);
    AXI_RVALID = 1'b0;
    tick();
    AXI_RESETn = 1'b1;
    IC_REQ = 1'b1; IC_ADDR = 32'h600;
    DC_REQ = 1'b1; DC_ADDR = 32'h700;
    tick();
    check_eq("ar_first_prot", LW'(AXI_ARPROT), LW'(3'b100));
    check_eq("ar_first_addr", LW'(AXI_ARADDR), LW'(32'h600));
    tick();
    AXI_RVALID = 1'b1; AXI_RDATA = line_a5;
    tick();
    AXI_RVALID = 1'b0;
    check_eq("ar_ic_valid", LW'({IC_VALID, DC_VALID}), LW'(2'b10));
    IC_REQ = 1'b0; DC_REQ = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
